// File: rtl/uart_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_fifo_ctrl_if
//   Bundles the push/pop, flag and error signals of one uart_fifo_ctrl
//   instance. Clock and reset are not part of the bundle.
//
//   master : the UART datapath side (drives requests, reads flags/data)
//   slave  : the FIFO controller itself
//
//   Signals:
//     FIFO_Enable_i  1 = FIFO mode (DEPTH words), 0 = holding-register mode
//     Flush_i        synchronous flush
//     Push_i/DAT_i   write request and data
//     Pop_i          read request
//     DAT_o          head-of-FIFO word (0 when empty)
//     Level_o        words stored
//     Empty_o/Full_o/Almost_Full_o/Trig_o   registered level flags
//     Trig_Level_i   trigger threshold
//     Overrun_o/Underrun_o  sticky error flags, cleared by Err_Clr_i
//
//   Optional (macro UART_FIFO_TIMEOUT_EN): Timeout_Cyc_i, Timeout_o.
// ---------------------------------------------------------------------------
interface uart_fifo_ctrl_if #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned TIMEOUT_W  = 12
);

  logic                  FIFO_Enable_i;
  logic                  Flush_i;
  logic                  Push_i;
  logic [DATA_W-1:0]     DAT_i;
  logic                  Pop_i;
  logic [DATA_W-1:0]     DAT_o;
  logic [DEPTH_LOG2:0]   Level_o;
  logic                  Empty_o;
  logic                  Full_o;
  logic                  Almost_Full_o;
  logic [DEPTH_LOG2:0]   Trig_Level_i;
  logic                  Trig_o;
  logic                  Overrun_o;
  logic                  Underrun_o;
  logic                  Err_Clr_i;
`ifdef UART_FIFO_TIMEOUT_EN
  logic [TIMEOUT_W-1:0]  Timeout_Cyc_i;
  logic                  Timeout_o;
`endif

`ifdef UART_FIFO_TIMEOUT_EN
  modport master (
    output FIFO_Enable_i, Flush_i, Push_i, DAT_i, Pop_i, Trig_Level_i, Err_Clr_i,
    output Timeout_Cyc_i,
    input  DAT_o, Level_o, Empty_o, Full_o, Almost_Full_o, Trig_o, Overrun_o, Underrun_o,
    input  Timeout_o
  );

  modport slave (
    input  FIFO_Enable_i, Flush_i, Push_i, DAT_i, Pop_i, Trig_Level_i, Err_Clr_i,
    input  Timeout_Cyc_i,
    output DAT_o, Level_o, Empty_o, Full_o, Almost_Full_o, Trig_o, Overrun_o, Underrun_o,
    output Timeout_o
  );
`else
  modport master (
    output FIFO_Enable_i, Flush_i, Push_i, DAT_i, Pop_i, Trig_Level_i, Err_Clr_i,
    input  DAT_o, Level_o, Empty_o, Full_o, Almost_Full_o, Trig_o, Overrun_o, Underrun_o
  );

  modport slave (
    input  FIFO_Enable_i, Flush_i, Push_i, DAT_i, Pop_i, Trig_Level_i, Err_Clr_i,
    output DAT_o, Level_o, Empty_o, Full_o, Almost_Full_o, Trig_o, Overrun_o, Underrun_o
  );
`endif

endinterface

// File: rtl/uart_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_fifo_ctrl
//   Synchronous first-word-fall-through FIFO with level, flag, trigger and
//   error logic for the UART 16550 Rx/Tx datapaths. Storage is an inferred
//   RAM of 2**DEPTH_LOG2 words; with FIFO_Enable_i=0 it behaves as the 16550
//   one-word holding register.
//
//   Ports:
//     WBs_CLK_i    fabric clock, rising edge
//     WBs_RST_n_i  asynchronous active-low reset
//     bus          uart_fifo_ctrl_if.slave (requests, data, flags, errors)
//
//   Optional feature, macro UART_FIFO_TIMEOUT_EN: character-timeout counter
//   (bus.Timeout_Cyc_i / bus.Timeout_o). Without the macro the counter and
//   its interface signals do not exist.
// ---------------------------------------------------------------------------
module uart_fifo_ctrl #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned DEPTH_LOG2   = 9,
  parameter int unsigned AFULL_MARGIN = 4,
  parameter int unsigned TIMEOUT_W    = 12
) (
  input logic             WBs_CLK_i,
  input logic             WBs_RST_n_i,
  uart_fifo_ctrl_if.slave bus
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned LvlW  = DEPTH_LOG2 + 1;

  localparam logic [LvlW-1:0] DepthLvl    = LvlW'(Depth);
  localparam logic [LvlW-1:0] AfullMargin = LvlW'(AFULL_MARGIN);

  // Storage (never reset)
  logic [DATA_W-1:0] mem [Depth];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic [LvlW-1:0]       capacity;

  logic empty_q, empty_d;
  logic full_q,  full_d;
  logic afull_q, afull_d;
  logic trig_q,  trig_d;
  logic ovr_q,   ovr_d;
  logic unr_q,   unr_d;

  logic push_eff, pop_eff;
  logic ovr_evt, unr_evt;

  // Requests are qualified by the registered flags only, so there is no
  // combinational path from Push_i/Pop_i into any flag.
  always_comb begin
    capacity = bus.FIFO_Enable_i ? DepthLvl : LvlW'(1);
    push_eff = bus.Push_i & ~full_q;
    pop_eff  = bus.Pop_i  & ~empty_q;
    ovr_evt  = bus.Push_i &  full_q;
    unr_evt  = bus.Pop_i  &  empty_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    empty_d  = empty_q;
    full_d   = full_q;
    afull_d  = afull_q;
    trig_d   = trig_q;
    ovr_d    = ovr_q;
    unr_d    = unr_q;

    if (bus.Flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      empty_d  = 1'b1;
      full_d   = 1'b0;
      afull_d  = 1'b0;
      trig_d   = 1'b0;
      ovr_d    = 1'b0;
      unr_d    = 1'b0;
    end else begin
      // Holding-register mode keeps both pointers parked at word 0.
      if (push_eff) begin
        wr_ptr_d = bus.FIFO_Enable_i ? wr_ptr_q + 1'b1 : '0;
      end
      if (pop_eff) begin
        rd_ptr_d = bus.FIFO_Enable_i ? rd_ptr_q + 1'b1 : '0;
      end

      unique case ({push_eff, pop_eff})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase

      empty_d = (level_d == '0);
      full_d  = (level_d == capacity);
      afull_d = ((capacity - level_d) <= AfullMargin);
      trig_d  = (bus.Trig_Level_i != '0) && (level_d >= bus.Trig_Level_i);

      // A fresh error in the clear cycle keeps the flag set.
      ovr_d = ovr_evt | (ovr_q & ~bus.Err_Clr_i);
      unr_d = unr_evt | (unr_q & ~bus.Err_Clr_i);
    end
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      trig_q   <= 1'b0;
      ovr_q    <= 1'b0;
      unr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      trig_q   <= trig_d;
      ovr_q    <= ovr_d;
      unr_q    <= unr_d;
    end
  end

  // RAM write port; no reset so the array maps onto inferred RAM.
  always_ff @(posedge WBs_CLK_i) begin
    if (push_eff && !bus.Flush_i) begin
      mem[wr_ptr_q] <= bus.DAT_i;
    end
  end

  // First-word-fall-through read: the head word is visible as soon as the
  // FIFO is non-empty.
  assign bus.DAT_o         = empty_q ? '0 : mem[rd_ptr_q];
  assign bus.Level_o       = level_q;
  assign bus.Empty_o       = empty_q;
  assign bus.Full_o        = full_q;
  assign bus.Almost_Full_o = afull_q;
  assign bus.Trig_o        = trig_q;
  assign bus.Overrun_o     = ovr_q;
  assign bus.Underrun_o    = unr_q;

`ifdef UART_FIFO_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts idle cycles while data sits in the FIFO; saturates at the
  // programmed limit so Timeout_o stays up until the next access.
  always_comb begin
    if (bus.Flush_i || push_eff || pop_eff || empty_q) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q >= bus.Timeout_Cyc_i) begin
      tmo_cnt_d = bus.Timeout_Cyc_i;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign bus.Timeout_o = (tmo_cnt_q == bus.Timeout_Cyc_i) && (bus.Timeout_Cyc_i != '0);
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_fifo_ctrl
//   Self-checking bench for uart_fifo_ctrl (DEPTH_LOG2=4). A queue-based
//   model tracks the expected contents and flags; a compare process checks
//   every output on each falling edge, and directed sections pin key values
//   with literal expectations. Define UART_FIFO_TIMEOUT_EN to also cover the
//   character-timeout counter.
// ---------------------------------------------------------------------------
module tb_uart_fifo_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DL    = 4;
  localparam int unsigned AFM   = 4;
  localparam int unsigned TW    = 12;
  localparam int          Depth = 16;
  localparam int          TmoCyc = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  uart_fifo_ctrl_if #(.DATA_W(DW), .DEPTH_LOG2(DL), .TIMEOUT_W(TW)) bus ();

  uart_fifo_ctrl #(
    .DATA_W      (DW),
    .DEPTH_LOG2  (DL),
    .AFULL_MARGIN(AFM),
    .TIMEOUT_W   (TW)
  ) dut (
    .WBs_CLK_i  (clk),
    .WBs_RST_n_i(rst_n),
    .bus        (bus)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] mq[$];
  bit m_full, m_afull, m_trig, m_ovr, m_unr;
  int m_tmo;
  int m_cap, m_lvl;
  bit m_was_empty, m_dpush, m_dpop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_full = 0; m_afull = 0; m_trig = 0; m_ovr = 0; m_unr = 0; m_tmo = 0;
    end else begin
      m_cap       = bus.FIFO_Enable_i ? Depth : 1;
      m_was_empty = (mq.size() == 0);
      if (bus.Flush_i) begin
        mq.delete();
        m_full = 0; m_afull = 0; m_trig = 0; m_ovr = 0; m_unr = 0; m_tmo = 0;
      end else begin
        m_dpush = bus.Push_i && !m_full;
        m_dpop  = bus.Pop_i && !m_was_empty;
        if (bus.Push_i && m_full) m_ovr = 1;
        else if (bus.Err_Clr_i)   m_ovr = 0;
        if (bus.Pop_i && m_was_empty) m_unr = 1;
        else if (bus.Err_Clr_i)       m_unr = 0;
        if (m_dpop)  void'(mq.pop_front());
        if (m_dpush) mq.push_back(bus.DAT_i);
        m_lvl   = mq.size();
        m_full  = (m_lvl == m_cap);
        m_afull = ((m_cap - m_lvl) <= int'(AFM));
        m_trig  = (bus.Trig_Level_i != 0) && (m_lvl >= int'(bus.Trig_Level_i));
        if (m_dpush || m_dpop || m_was_empty) m_tmo = 0;
        else if (m_tmo < TmoCyc)             m_tmo = m_tmo + 1;
        else                                  m_tmo = TmoCyc;
      end
    end
  end

  function automatic logic [7:0] model_head();
    if (mq.size() == 0) return 8'h00;
    return mq[0];
  endfunction

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("dat",      bus.DAT_o,         model_head());
      check("level",    bus.Level_o,       mq.size());
      check("empty",    bus.Empty_o,       mq.size() == 0);
      check("full",     bus.Full_o,        m_full);
      check("afull",    bus.Almost_Full_o, m_afull);
      check("trig",     bus.Trig_o,        m_trig);
      check("overrun",  bus.Overrun_o,     m_ovr);
      check("underrun", bus.Underrun_o,    m_unr);
`ifdef UART_FIFO_TIMEOUT_EN
      check("timeout",  bus.Timeout_o,     m_tmo == TmoCyc);
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+2; returns at the following posedge+2.
  task automatic cyc(input bit pu, input bit po, input logic [7:0] d, input bit fl,
                     input bit cl);
    bus.Push_i    = pu;
    bus.Pop_i     = po;
    bus.DAT_i     = d;
    bus.Flush_i   = fl;
    bus.Err_Clr_i = cl;
    @(posedge clk);
    #2;
    bus.Push_i    = 1'b0;
    bus.Pop_i     = 1'b0;
    bus.DAT_i     = '0;
    bus.Flush_i   = 1'b0;
    bus.Err_Clr_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_level"}, bus.Level_o,       0);
    check({tag, "_empty"}, bus.Empty_o,       1);
    check({tag, "_full"},  bus.Full_o,        0);
    check({tag, "_afull"}, bus.Almost_Full_o, 0);
    check({tag, "_trig"},  bus.Trig_o,        0);
    check({tag, "_ovr"},   bus.Overrun_o,     0);
    check({tag, "_unr"},   bus.Underrun_o,    0);
    check({tag, "_dat"},   bus.DAT_o,         0);
  endtask

  int lvl;
  bit pu, po;

  initial begin
    bus.FIFO_Enable_i = 1'b1;
    bus.Flush_i       = 1'b0;
    bus.Push_i        = 1'b0;
    bus.Pop_i         = 1'b0;
    bus.DAT_i         = '0;
    bus.Trig_Level_i  = '0;
    bus.Err_Clr_i     = 1'b0;
`ifdef UART_FIFO_TIMEOUT_EN
    bus.Timeout_Cyc_i = TW'(TmoCyc);
`endif

    // Reset
    #3 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    #10;
    check_reset_vals("rst");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic FIFO order, FWFT head
    for (int i = 1; i <= 5; i++) cyc(1, 0, 8'(i), 0, 0);
    check("basic_level", bus.Level_o, 5);
    check("basic_head",  bus.DAT_o,   8'h01);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 1, 8'h00, 0, 0);
      check("basic_pop_dat", bus.DAT_o, (i < 5) ? 32'(i + 1) : 32'h0);
    end
    check("basic_empty", bus.Empty_o, 1);

    // Fill to full, almost-full threshold, overrun, clear
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 8'($urandom), 0, 0);
      if (i == 10) check("afull_at11", bus.Almost_Full_o, 0);
      if (i == 11) check("afull_at12", bus.Almost_Full_o, 1);
    end
    check("full_flag",  bus.Full_o,  1);
    check("full_level", bus.Level_o, 16);
    cyc(1, 0, 8'hEE, 0, 0);
    check("ovr_level", bus.Level_o,   16);
    check("ovr_set",   bus.Overrun_o, 1);
    cyc(0, 0, 8'h00, 0, 1);
    check("ovr_clr",   bus.Overrun_o, 0);

    // Full + push + pop: pop only
    cyc(1, 1, 8'h77, 0, 0);
    check("fullpp_level", bus.Level_o,   15);
    check("fullpp_ovr",   bus.Overrun_o, 1);
    cyc(0, 0, 8'h00, 1, 0);
    check("flush_level", bus.Level_o,   0);
    check("flush_ovr",   bus.Overrun_o, 0);
    // Empty + push + pop: push only
    cyc(1, 1, 8'h3C, 0, 0);
    check("emptypp_level", bus.Level_o,    1);
    check("emptypp_unr",   bus.Underrun_o, 1);
    check("emptypp_dat",   bus.DAT_o,      8'h3C);
    cyc(0, 0, 8'h00, 1, 0);

    // Pointer wrap with level kept in 3..10
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'($urandom), 0, 0);
    for (int i = 0; i < 60; i++) begin
      lvl = mq.size();
      pu = (lvl <= 3) ? 1'b1 : (lvl >= 10) ? 1'b0 : ($urandom_range(0, 9) < 6);
      po = (lvl >= 10) ? 1'b1 : (lvl <= 3) ? 1'b0 : ($urandom_range(0, 9) < 4);
      cyc(pu, po, 8'($urandom), 0, 0);
    end
    cyc(0, 0, 8'h00, 1, 0);

    // Fully random traffic, mode changes always paired with a flush
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 19) == 0) bus.Trig_Level_i = 5'($urandom_range(0, 16));
      if ($urandom_range(0, 59) == 0) begin
        bus.FIFO_Enable_i = ($urandom_range(0, 3) != 0);
        cyc(0, 0, 8'h00, 1, 0);
      end else begin
        // Bias alternates so the FIFO swings between empty and full.
        pu = ((i / 100) % 2 == 0) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
        po = ((i / 100) % 2 == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
        cyc(pu, po, 8'($urandom), 0, $urandom_range(0, 19) == 0);
      end
    end

    // Holding-register mode
    bus.Trig_Level_i  = '0;
    bus.FIFO_Enable_i = 1'b0;
    cyc(0, 0, 8'h00, 1, 0);
    cyc(1, 0, 8'hA5, 0, 0);
    check("hold_full",  bus.Full_o,  1);
    check("hold_dat",   bus.DAT_o,   8'hA5);
    bus.Trig_Level_i = 5'd1;
    cyc(1, 0, 8'h5A, 0, 0);
    check("hold_ovr",   bus.Overrun_o, 1);
    check("hold_dat2",  bus.DAT_o,     8'hA5);
    check("hold_level", bus.Level_o,   1);
    check("hold_trig",  bus.Trig_o,    1);
    bus.Trig_Level_i  = '0;
    bus.FIFO_Enable_i = 1'b1;
    cyc(0, 0, 8'h00, 1, 0);

`ifdef UART_FIFO_TIMEOUT_EN
    // Character timeout
    cyc(1, 0, 8'h11, 0, 0);
    cyc(1, 0, 8'h22, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc(0, 0, 8'h00, 0, 0);
      check("tmo_idle", bus.Timeout_o, k >= 10);
    end
    cyc(0, 1, 8'h00, 0, 0);
    check("tmo_pop", bus.Timeout_o, 0);
    cyc(0, 0, 8'h00, 1, 0);
`endif

    // Asynchronous reset in the middle of operation
    for (int i = 0; i < 7; i++) cyc(1, 0, 8'($urandom), 0, 0);
    check("mid_level", bus.Level_o, 7);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(1, 0, 8'h99, 0, 0);
    check("post_rst_dat", bus.DAT_o, 8'h99);

    cyc(0, 0, 8'h00, 0, 0);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
